// File: rtl/vram_commit_arbiter.sv
// -----------------------------------------------------------------------------
// vram_commit_arbiter
//
// Purpose:
//   Consumer end of the CPU store queue. Commits queued 6502 writes into the
//   single-port vector RAM and shares that port with vector-generator reads.
//   Reads win by default. A bounded-deferral counter forces a write slot after
//   MAX_DEFER consecutive lost cycles, so queued writes always make progress.
//   Writes that fall outside the vector window are dropped and counted.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   wr_pending    store queue non-empty
//   wr_valid      queue head popped this cycle (queue drives canWrite && !empty)
//   wr_data       queue head data
//   wr_addr       queue head CPU address
//   can_write     arbiter accepts queue head this cycle
//   vg_rd_req     vector generator read request, held until granted
//   vg_rd_addr    vector RAM read address
//   vg_rd_gnt     read issued to BRAM this cycle
//   vg_rd_valid   vg_rd_data valid (cycle after grant)
//   vg_rd_data    read data
//   bram_addr     BRAM address
//   bram_din      BRAM write data
//   bram_we       BRAM write enable
//   bram_dout     BRAM read data, 1-cycle latency
//   drop_count    saturating count of out-of-window writes
//
// Handshake:
//   can_write is the queue's canWrite. It depends only on the force flag and
//   vg_rd_req (and is held low in reset). A write is committed on a cycle where
//   wr_valid && can_write. wr_valid without can_write is ignored.
//   vg_rd_req/vg_rd_addr are held by the requester until vg_rd_gnt is seen.
//   Data returns with vg_rd_valid exactly one cycle after vg_rd_gnt.
// -----------------------------------------------------------------------------
module vram_commit_arbiter #(
    parameter logic [15:0] VRAM_BASE = 16'h2000,
    parameter int          VRAM_AW   = 13,
    parameter int          MAX_DEFER = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_pending,
    input  logic               wr_valid,
    input  logic [7:0]         wr_data,
    input  logic [15:0]        wr_addr,
    output logic               can_write,
    input  logic               vg_rd_req,
    input  logic [VRAM_AW-1:0] vg_rd_addr,
    output logic               vg_rd_gnt,
    output logic               vg_rd_valid,
    output logic [7:0]         vg_rd_data,
    output logic [VRAM_AW-1:0] bram_addr,
    output logic [7:0]         bram_din,
    output logic               bram_we,
    input  logic [7:0]         bram_dout,
    output logic [7:0]         drop_count
);

    localparam int DW = $clog2(MAX_DEFER + 1);

    logic [DW-1:0] r_defer_cnt;
    logic          r_force;
    logic          r_rd_valid;
    logic [7:0]    r_rd_hold;
    logic [7:0]    r_drop_count;

    logic [15:0]   w_offset;
    logic          w_in_win;
    logic          w_can_write;
    logic          w_gnt;
    logic          w_commit;
    logic          w_drop;
    logic [DW-1:0] w_defer_inc;

    // Arbitration: force wins, then reads, otherwise the write slot is open.
    // Nothing here looks at wr_valid, because the queue builds wr_valid from
    // can_write and a dependency would form a combinational loop.
    always_comb begin
        w_can_write = 1'b0;
        w_gnt       = 1'b0;
        if (!rst) begin
            if (r_force) begin
                w_can_write = 1'b1;
            end else if (vg_rd_req) begin
                w_gnt = 1'b1;
            end else begin
                w_can_write = 1'b1;
            end
        end
    end

    // Window test uses the wrapped 16-bit offset, so addresses below the base
    // become large offsets and fall out of range as well.
    assign w_offset    = wr_addr - VRAM_BASE;
    assign w_in_win    = (32'(w_offset) < (32'd1 << VRAM_AW));
    assign w_commit    = wr_valid && w_can_write;
    assign w_drop      = w_commit && !w_in_win;
    assign w_defer_inc = r_defer_cnt + DW'(1);

    assign can_write   = w_can_write;
    assign vg_rd_gnt   = w_gnt;
    assign bram_we     = w_commit && w_in_win;
    assign bram_din    = wr_data;
    assign bram_addr   = w_gnt ? vg_rd_addr : w_offset[VRAM_AW-1:0];
    assign drop_count  = r_drop_count;
    assign vg_rd_valid = r_rd_valid && !rst;

    // The BRAM output register is the capture stage: bram_dout already holds
    // the granted word in the valid cycle. r_rd_hold keeps the last word
    // afterwards so vg_rd_data is stable (and 0 after reset).
    assign vg_rd_data  = r_rd_valid ? bram_dout : r_rd_hold;

    // Deferral: count cycles where a pending write lost to a read. Reaching
    // MAX_DEFER arms force for exactly the next cycle; the force cycle then
    // clears both, whether or not the queue popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_defer_cnt <= '0;
            r_force     <= 1'b0;
        end else if (r_force) begin
            r_defer_cnt <= '0;
            r_force     <= 1'b0;
        end else if (wr_valid || !wr_pending) begin
            r_defer_cnt <= '0;
        end else if (w_gnt) begin
            r_defer_cnt <= w_defer_inc;
            r_force     <= (w_defer_inc == DW'(MAX_DEFER));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_hold  <= 8'h00;
        end else begin
            r_rd_valid <= w_gnt;
            if (r_rd_valid) begin
                r_rd_hold <= bram_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= 8'h00;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'h01;
        end
    end

endmodule

// File: tb/tb_vram_commit_arbiter.sv
module tb_vram_commit_arbiter;

    localparam int MAX_DEFER = 4;
    localparam int DEPTH     = 8192;

    // ---------------------------------------------------------------- clock/reset
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_pending;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic [15:0] wr_addr;
    logic        can_write;
    logic        vg_rd_req;
    logic [12:0] vg_rd_addr;
    logic        vg_rd_gnt;
    logic        vg_rd_valid;
    logic [7:0]  vg_rd_data;
    logic [12:0] bram_addr;
    logic [7:0]  bram_din;
    logic        bram_we;
    logic [7:0]  bram_dout;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    vram_commit_arbiter #(
        .VRAM_BASE (16'h2000),
        .VRAM_AW   (13),
        .MAX_DEFER (MAX_DEFER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_pending  (wr_pending),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_addr     (wr_addr),
        .can_write   (can_write),
        .vg_rd_req   (vg_rd_req),
        .vg_rd_addr  (vg_rd_addr),
        .vg_rd_gnt   (vg_rd_gnt),
        .vg_rd_valid (vg_rd_valid),
        .vg_rd_data  (vg_rd_data),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_we     (bram_we),
        .bram_dout   (bram_dout),
        .drop_count  (drop_count)
    );

    // Single-port BRAM, read-first, 1-cycle read latency.
    logic [7:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    // ---------------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: shadow RAM contents, pending read results, drop total,
    // and the length of the current streak of cycles a waiting write lost.
    logic [7:0] shadow [0:DEPTH-1];
    logic [7:0] exp_q[$];
    int         m_drops;
    int         m_streak;
    bit         m_force;
    bit         m_rd_valid;
    bit         last_gnt;

    task automatic model_reset();
        m_drops    = 0;
        m_streak   = 0;
        m_force    = 0;
        m_rd_valid = 0;
        exp_q.delete();
    endtask

    // ---------------------------------------------------------------- driver
    // One clock cycle: drive inputs at negedge, check all outputs, advance model.
    task automatic cycle(input bit r, input bit pend, input bit pop,
                         input logic [15:0] a, input logic [7:0] d,
                         input bit rq, input logic [12:0] ra, input bit perr);
        bit exp_cw, exp_gnt, wv, commit, in_win;
        logic [15:0] off;
        logic [7:0]  exp_data;
        @(negedge clk);
        exp_cw  = !r && (m_force || !rq);
        exp_gnt = !r && !m_force && rq;
        wv      = pend && pop && (exp_cw || perr);
        commit  = wv && exp_cw;
        off     = a - 16'h2000;
        in_win  = (int'(off) < DEPTH);
        rst        = r;
        wr_pending = pend;
        wr_valid   = wv;
        wr_addr    = a;
        wr_data    = d;
        vg_rd_req  = rq;
        vg_rd_addr = ra;
        #1;
        check("can_write", 32'(can_write), 32'(exp_cw));
        check("vg_rd_gnt", 32'(vg_rd_gnt), 32'(exp_gnt));
        check("bram_we", 32'(bram_we), 32'(commit && in_win));
        if (commit && in_win) begin
            check("wr_bram_addr", 32'(bram_addr), 32'(off[12:0]));
            check("wr_bram_din", 32'(bram_din), 32'(d));
        end
        if (exp_gnt) check("rd_bram_addr", 32'(bram_addr), 32'(ra));
        check("vg_rd_valid", 32'(vg_rd_valid), 32'(!r && m_rd_valid));
        if (!r && m_rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_queue_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_data = exp_q.pop_front();
                check("vg_rd_data", 32'(vg_rd_data), 32'(exp_data));
            end
        end
        check("drop_count", 32'(drop_count), 32'(m_drops));

        last_gnt = exp_gnt;
        if (r) begin
            model_reset();
        end else begin
            exp_q.delete();
            if (commit && in_win) shadow[off[12:0]] = d;
            if (commit && !in_win && m_drops < 255) m_drops++;
            m_rd_valid = exp_gnt;
            if (exp_gnt) exp_q.push_back(shadow[ra]);
            if (m_force) begin
                m_force  = 0;
                m_streak = 0;
            end else if (!pend || wv) begin
                m_streak = 0;
            end else if (exp_gnt) begin
                m_streak++;
                if (m_streak == MAX_DEFER) m_force = 1;
            end
        end
    endtask

    function automatic logic [15:0] out_addr();
        if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 16'h1FFF));
        return 16'($urandom_range(16'h4000, 16'hFFFF));
    endfunction

    // ---------------------------------------------------------------- stimulus
    int  gnt_run;
    bit  held_rq;
    logic [12:0] held_ra;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        rst = 1'b1; wr_pending = 0; wr_valid = 0; wr_data = 0; wr_addr = 0;
        vg_rd_req = 0; vg_rd_addr = 0;
        model_reset();

        cycle(1, 0, 0, 16'h0, 8'h0, 0, 13'h0, 0);
        cycle(1, 0, 0, 16'h0, 8'h0, 0, 13'h0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rd_data", 32'(vg_rd_data), 32'h0);
        check("reset_drop", 32'(drop_count), 32'h0);
        check("reset_valid", 32'(vg_rd_valid), 32'h0);

        // Write then read back the same address.
        cycle(0, 1, 1, 16'h2005, 8'hA5, 0, 13'h0, 0);
        cycle(0, 0, 0, 16'h0, 8'h0, 1, 13'h0005, 0);
        cycle(0, 0, 0, 16'h0, 8'h0, 0, 13'h0, 0);
        check("readback_A5", 32'(vg_rd_data), 32'hA5);

        // Continuous reads with a waiting write: exactly MAX_DEFER grants first.
        gnt_run = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 1, 16'h2100 + 16'(i), 8'(8'h30 + i), 1, 13'(i), 0);
            if (i < 5 && last_gnt) gnt_run++;
        end
        check("defer_grant_run", 32'(gnt_run), 32'(MAX_DEFER));
        cycle(0, 0, 0, 16'h0, 8'h0, 0, 13'h0, 0);

        // Out-of-window drops, then saturation.
        cycle(0, 1, 1, 16'h0100, 8'h11, 0, 13'h0, 0);
        cycle(0, 1, 1, 16'h4000, 8'h22, 0, 13'h0, 0);
        cycle(0, 1, 1, 16'h1FFF, 8'h33, 0, 13'h0, 0);
        cycle(0, 0, 0, 16'h0, 8'h0, 0, 13'h0, 0);
        check("drop_three", 32'(drop_count), 32'd3);
        for (int i = 0; i < 300; i++)
            cycle(0, 1, 1, out_addr(), 8'($urandom), 0, 13'h0, 0);
        cycle(0, 0, 0, 16'h0, 8'h0, 0, 13'h0, 0);
        check("drop_saturated", 32'(drop_count), 32'hFF);

        // Reset right after a read grant, with deferral partly built up.
        cycle(0, 1, 0, 16'h2000, 8'h0, 1, 13'h0005, 0);
        cycle(0, 1, 0, 16'h2000, 8'h0, 1, 13'h0005, 0);
        cycle(1, 0, 0, 16'h0, 8'h0, 0, 13'h0, 0);
        cycle(0, 0, 0, 16'h0, 8'h0, 0, 13'h0, 0);
        check("post_reset_valid", 32'(vg_rd_valid), 32'h0);
        check("post_reset_drop", 32'(drop_count), 32'h0);
        gnt_run = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 1, 16'h2200, 8'h5A, 1, 13'h0010, 0);
            if (i < 5 && last_gnt) gnt_run++;
        end
        check("defer_restart_run", 32'(gnt_run), 32'(MAX_DEFER));

        // No pending writes, toggling reads: every request granted immediately.
        gnt_run = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 0, 0, 16'h0, 8'h0, (i % 2) == 0, 13'($urandom_range(0, DEPTH - 1)), 0);
            if (last_gnt) gnt_run++;
        end
        check("toggle_grants", 32'(gnt_run), 32'd6);

        // Randomized traffic against the model.
        held_rq = 0;
        held_ra = 0;
        for (int i = 0; i < 3000; i++) begin
            bit rq;
            bit pend;
            logic [12:0] ra;
            logic [15:0] a;
            if (held_rq) begin
                rq = 1;
                ra = held_ra;
            end else begin
                rq = ($urandom_range(0, 99) < 55);
                ra = 13'($urandom_range(0, 63));
            end
            pend = ($urandom_range(0, 99) < 70);
            a = ($urandom_range(0, 3) != 0) ? 16'(16'h2000 + $urandom_range(0, 63)) : out_addr();
            cycle($urandom_range(0, 299) == 0, pend, $urandom_range(0, 99) < 60,
                  a, 8'($urandom), rq, ra, $urandom_range(0, 49) == 0);
            held_rq = rq && !last_gnt && !rst;
            held_ra = ra;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
